// File: rtl/data_mem_lsu_if.sv
// Request/response handshake bundle between the execute stage and the data memory LSU.
// master drives requests and accepts responses; slave is the LSU.
interface data_mem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_lsu.sv
// Byte-addressable data memory with RV32I load/store decode, byte-lane merging,
// load extension and error flagging; one outstanding request, latency RD_LAT.
module data_mem_lsu #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned RD_LAT = 1
) (
    input logic           clk,
    input logic           rst_n,
    data_mem_lsu_if.slave bus
);
    localparam int unsigned IdxW  = ADDR_W - 2;
    localparam int unsigned Depth = 2 ** IdxW;

    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
        $error("data_mem_lsu: RD_LAT must be 1 or 2");
    end
    if (ADDR_W < 4 || ADDR_W > 20) begin : g_bad_addr_w
        $error("data_mem_lsu: ADDR_W must be in 4..20");
    end

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e state_q, state_d;

    logic [31:0] mem [Depth] = '{default: 32'h0};

    logic            accept;
    logic            is_half;
    logic            is_word;
    logic            misaligned;
    logic            out_of_range;
    logic            illegal;
    logic            req_err;
    logic            wr_en;
    logic [IdxW-1:0] idx;
    logic [3:0]      be;
    logic [31:0]     wdata_rep;
    logic [31:0]     rd_word;
    logic [7:0]      rd_byte;
    logic [15:0]     rd_half;
    logic [31:0]     ld_data;
    logic [31:0]     rdata_q;
    logic            err_q;

    // req_ready is gated by rst_n so nothing is accepted while reset is held
    assign bus.req_ready = rst_n && (state_q == StIdle);
    assign bus.rsp_valid = (state_q == StResp);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    assign accept = bus.req_valid && bus.req_ready;
    assign idx    = bus.req_addr[ADDR_W-1:2];

    always_comb begin
        is_half      = (bus.req_funct3[1:0] == 2'b01);
        is_word      = (bus.req_funct3[1:0] == 2'b10);
        misaligned   = (is_half && bus.req_addr[0]) || (is_word && (bus.req_addr[1:0] != 2'b00));
        out_of_range = (bus.req_addr[31:ADDR_W] != '0);
        if (bus.req_we) begin
            illegal = (bus.req_funct3 >= 3'b011);
        end else begin
            illegal = (bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
                      (bus.req_funct3 == 3'b111);
        end
        req_err = misaligned || out_of_range || illegal;
        wr_en   = accept && bus.req_we && !req_err;
    end

    always_comb begin
        be        = 4'b0000;
        wdata_rep = bus.req_wdata;
        case (bus.req_funct3[1:0])
            2'b00: begin
                be        = 4'b0001 << bus.req_addr[1:0];
                wdata_rep = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                be        = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{bus.req_wdata[15:0]}};
            end
            2'b10: begin
                be        = 4'b1111;
                wdata_rep = bus.req_wdata;
            end
            default: begin
                be        = 4'b0000;
                wdata_rep = bus.req_wdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en && be[i]) begin
                mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
            end
        end
    end

    always_comb begin
        rd_word = mem[idx];
        rd_byte = rd_word[{bus.req_addr[1:0], 3'b000} +: 8];
        rd_half = rd_word[{bus.req_addr[1], 4'b0000} +: 16];
        case (bus.req_funct3)
            3'b000:  ld_data = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  ld_data = {{16{rd_half[15]}}, rd_half};
            3'b010:  ld_data = rd_word;
            3'b100:  ld_data = {24'h0, rd_byte};
            3'b101:  ld_data = {16'h0, rd_half};
            default: ld_data = 32'h0;
        endcase
    end

    // Response is captured at accept and held untouched through WAIT and RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else if (accept) begin
            err_q   <= req_err;
            rdata_q <= (bus.req_we || req_err) ? 32'h0 : ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = (RD_LAT == 2) ? StWait : StResp;
                end
            end
            StWait: state_d = StResp;
            StResp: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end
endmodule

// File: tb/tb_data_mem_lsu.sv
// Self-checking bench for data_mem_lsu: directed vector table, handshake corner cases,
// reset drop on RD_LAT=2, and randomized traffic against a byte-level reference model.
module tb_data_mem_lsu;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    data_mem_lsu_if bus1();
    data_mem_lsu_if bus2();

    data_mem_lsu #(.ADDR_W(14), .RD_LAT(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    data_mem_lsu #(.ADDR_W(14), .RD_LAT(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

    // Shared stimulus, steered to one DUT by sel
    logic        sel;
    logic        t_valid;
    logic        t_we;
    logic [2:0]  t_f3;
    logic [31:0] t_addr;
    logic [31:0] t_wdata;
    logic        t_rsp_ready;

    assign bus1.req_valid  = t_valid && !sel;
    assign bus1.req_we     = t_we;
    assign bus1.req_funct3 = t_f3;
    assign bus1.req_addr   = t_addr;
    assign bus1.req_wdata  = t_wdata;
    assign bus1.rsp_ready  = t_rsp_ready && !sel;
    assign bus2.req_valid  = t_valid && sel;
    assign bus2.req_we     = t_we;
    assign bus2.req_funct3 = t_f3;
    assign bus2.req_addr   = t_addr;
    assign bus2.req_wdata  = t_wdata;
    assign bus2.rsp_ready  = t_rsp_ready && sel;

    logic        o_req_ready;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;
    assign o_req_ready = sel ? bus2.req_ready : bus1.req_ready;
    assign o_rsp_valid = sel ? bus2.rsp_valid : bus1.rsp_valid;
    assign o_rsp_rdata = sel ? bus2.rsp_rdata : bus1.rsp_rdata;
    assign o_rsp_err   = sel ? bus2.rsp_err   : bus1.rsp_err;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input int stall,
                          output logic [31:0] rdata, output logic err, output int lat);
        int guard;
        rdata = 32'h0;
        err   = 1'b0;
        lat   = -1;
        @(negedge clk);
        t_we        = we;
        t_f3        = f3;
        t_addr      = addr;
        t_wdata     = wdata;
        t_rsp_ready = (stall == 0);
        t_valid     = 1'b1;
        guard = 0;
        while (!o_req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!o_req_ready) begin
            check32("accept_timeout", 32'(o_req_ready), 32'h1);
            t_valid = 1'b0;
            return;
        end
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            t_valid = 1'b0;
            lat++;
        end while (!o_rsp_valid && lat < 20);
        if (!o_rsp_valid) begin
            check32("rsp_timeout", 32'(o_rsp_valid), 32'h1);
            return;
        end
        rdata = o_rsp_rdata;
        err   = o_rsp_err;
        for (int i = 0; i < stall; i++) @(negedge clk);
        t_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    // Reference model: byte-addressed storage of the low 256 bytes
    logic [7:0] mref [256];

    task automatic model_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata,
                                output logic [31:0] exp_rdata, output logic exp_err);
        bit          legal;
        int unsigned size;
        longint      val;
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size  = 1 << f3[1:0];
        exp_err   = !legal || ((addr % size) != 0) || (addr >= 32'h4000);
        exp_rdata = 32'h0;
        if (exp_err) return;
        if (we) begin
            for (int i = 0; i < int'(size); i++) mref[addr + i] = wdata[8*i +: 8];
        end else begin
            val = 0;
            for (int i = 0; i < int'(size); i++) val += longint'(mref[addr + i]) << (8 * i);
            if (!f3[2] && size < 4 && val >= (longint'(1) << (8 * size - 1)))
                val -= longint'(1) << (8 * size);
            exp_rdata = val[31:0];
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic [31:0] e_rd;
        logic        e_er;

        rst_n = 1'b0; sel = 1'b0; t_valid = 1'b0; t_we = 1'b0; t_f3 = 3'd0;
        t_addr = 32'h0; t_wdata = 32'h0; t_rsp_ready = 1'b0;

        repeat (3) @(negedge clk);
        check32("rst_req_ready1", 32'(bus1.req_ready), 32'h0);
        check32("rst_rsp_valid1", 32'(bus1.rsp_valid), 32'h0);
        check32("rst_rsp_rdata1", bus1.rsp_rdata, 32'h0);
        check32("rst_rsp_err1",   32'(bus1.rsp_err), 32'h0);
        check32("rst_req_ready2", 32'(bus2.req_ready), 32'h0);
        check32("rst_rsp_valid2", 32'(bus2.rsp_valid), 32'h0);
        rst_n = 1'b1;
        #1;
        check32("post_rst_ready1", 32'(bus1.req_ready), 32'h1);
        check32("post_rst_ready2", 32'(bus2.req_ready), 32'h1);

        // we, f3, addr, wdata, expected rdata, expected err
        vecs.push_back('{1'b1, 3'd2, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 3'd2, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b1, 3'd2, 32'h20,   32'h11223344, 32'h0,        1'b0});
        vecs.push_back('{1'b1, 3'd0, 32'h22,   32'h000000AA, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 3'd2, 32'h20,   32'h0,        32'h11AA3344, 1'b0});
        vecs.push_back('{1'b1, 3'd1, 32'h20,   32'h00005566, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 3'd2, 32'h20,   32'h0,        32'h11AA5566, 1'b0});
        vecs.push_back('{1'b0, 3'd0, 32'h22,   32'h0,        32'hFFFFFFAA, 1'b0});
        vecs.push_back('{1'b0, 3'd4, 32'h23,   32'h0,        32'h00000011, 1'b0});
        vecs.push_back('{1'b0, 3'd1, 32'h22,   32'h0,        32'h000011AA, 1'b0});
        vecs.push_back('{1'b1, 3'd2, 32'h30,   32'h000080F0, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 3'd0, 32'h30,   32'h0,        32'hFFFFFFF0, 1'b0});
        vecs.push_back('{1'b0, 3'd4, 32'h30,   32'h0,        32'h000000F0, 1'b0});
        vecs.push_back('{1'b0, 3'd1, 32'h30,   32'h0,        32'hFFFF80F0, 1'b0});
        vecs.push_back('{1'b0, 3'd5, 32'h30,   32'h0,        32'h000080F0, 1'b0});
        vecs.push_back('{1'b1, 3'd2, 32'h40,   32'hCAFEF00D, 32'h0,        1'b0});
        vecs.push_back('{1'b1, 3'd2, 32'h42,   32'h12345678, 32'h0,        1'b1});
        vecs.push_back('{1'b0, 3'd2, 32'h40,   32'h0,        32'hCAFEF00D, 1'b0});
        vecs.push_back('{1'b0, 3'd2, 32'h4000, 32'h0,        32'h0,        1'b1});
        vecs.push_back('{1'b0, 3'd3, 32'h40,   32'h0,        32'h0,        1'b1});
        vecs.push_back('{1'b1, 3'd3, 32'h40,   32'hFFFFFFFF, 32'h0,        1'b1});
        vecs.push_back('{1'b1, 3'd1, 32'h41,   32'hFFFFFFFF, 32'h0,        1'b1});
        vecs.push_back('{1'b0, 3'd5, 32'h43,   32'h0,        32'h0,        1'b1});
        vecs.push_back('{1'b0, 3'd2, 32'h40,   32'h0,        32'hCAFEF00D, 1'b0});

        foreach (vecs[i]) begin
            do_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, 0, rd, er, lat);
            check32($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check32($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            check32($sformatf("vec%0d_lat", i), 32'(lat), 32'd1);
        end

        // Backpressure: response held stable while rsp_ready stays low
        @(negedge clk);
        t_we = 1'b0; t_f3 = 3'd2; t_addr = 32'h20; t_rsp_ready = 1'b0; t_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        t_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check32($sformatf("bp%0d_valid", i), 32'(o_rsp_valid), 32'h1);
            check32($sformatf("bp%0d_rdata", i), o_rsp_rdata, 32'h11AA5566);
            check32($sformatf("bp%0d_err", i), 32'(o_rsp_err), 32'h0);
            check32($sformatf("bp%0d_req_ready", i), 32'(o_req_ready), 32'h0);
            @(negedge clk);
        end
        t_rsp_ready = 1'b1;
        check32("bp_valid_before_release", 32'(o_rsp_valid), 32'h1);
        @(negedge clk);
        check32("bp_req_ready_after", 32'(o_req_ready), 32'h1);
        check32("bp_valid_after", 32'(o_rsp_valid), 32'h0);

        // Reset mid-RESP: response dropped, store already written
        @(negedge clk);
        t_we = 1'b1; t_f3 = 3'd2; t_addr = 32'h50; t_wdata = 32'h0BADCAFE;
        t_rsp_ready = 1'b0; t_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        t_valid = 1'b0;
        check32("rresp_valid_pre", 32'(o_rsp_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        check32("rresp_valid_rst", 32'(o_rsp_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check32("rresp_req_ready", 32'(o_req_ready), 32'h1);
        do_req(1'b0, 3'd2, 32'h50, 32'h0, 0, rd, er, lat);
        check32("rresp_store_kept", rd, 32'h0BADCAFE);

        // RD_LAT=2: reset during WAIT drops the response
        sel = 1'b1;
        @(negedge clk);
        t_we = 1'b0; t_f3 = 3'd2; t_addr = 32'h10; t_rsp_ready = 1'b1; t_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        t_valid = 1'b0;
        check32("wait_valid_low", 32'(o_rsp_valid), 32'h0);
        check32("wait_req_ready_low", 32'(o_req_ready), 32'h0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check32($sformatf("wdrop%0d_valid", i), 32'(o_rsp_valid), 32'h0);
            check32($sformatf("wdrop%0d_req_ready", i), 32'(o_req_ready), 32'h1);
            @(negedge clk);
        end
        do_req(1'b1, 3'd2, 32'h10, 32'h13579BDF, 0, rd, er, lat);
        check32("lat2_store_lat", 32'(lat), 32'd2);
        check32("lat2_store_err", 32'(er), 32'h0);
        do_req(1'b0, 3'd2, 32'h10, 32'h0, 0, rd, er, lat);
        check32("lat2_load_lat", 32'(lat), 32'd2);
        check32("lat2_load_rdata", rd, 32'h13579BDF);
        do_req(1'b0, 3'd0, 32'h11, 32'h0, 1, rd, er, lat);
        check32("lat2_lb_rdata", rd, 32'hFFFFFF9B);

        // Randomized traffic on RD_LAT=1 against the byte model
        sel = 1'b0;
        for (int w = 0; w < 64; w++) begin
            do_req(1'b1, 3'd2, 32'(w * 4), 32'h0, 0, rd, er, lat);
        end
        for (int i = 0; i < 256; i++) mref[i] = 8'h00;
        for (int n = 0; n < 300; n++) begin
            logic        r_we;
            logic [2:0]  r_f3;
            logic [31:0] r_addr;
            logic [31:0] r_wdata;
            r_we    = 1'($urandom_range(0, 1));
            r_f3    = 3'($urandom_range(0, 7));
            r_addr  = 32'($urandom_range(0, 255));
            r_wdata = $urandom;
            if ($urandom_range(0, 1) == 0) r_addr[1:0] = 2'b00;
            if ($urandom_range(0, 9) == 0) r_addr = r_addr | (32'h1 << $urandom_range(14, 31));
            model_access(r_we, r_f3, r_addr, r_wdata, e_rd, e_er);
            do_req(r_we, r_f3, r_addr, r_wdata, int'($urandom_range(0, 2)), rd, er, lat);
            check32($sformatf("rnd%0d_rdata we=%0d f3=%0d a=%h", n, r_we, r_f3, r_addr), rd, e_rd);
            check32($sformatf("rnd%0d_err we=%0d f3=%0d a=%h", n, r_we, r_f3, r_addr),
                    32'(er), 32'(e_er));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
